// File: rtl/sfifo_p_if.sv
// Producer/consumer bundle for sfifo_p: write/read requests, read data and status.
interface sfifo_p_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             wsig;
  logic [WIDTH-1:0] wdata;
  logic             rsig;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wsig, wdata, rsig,
    input  rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wsig, wdata, rsig,
    output rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sfifo_p.sv
// Single-clock parametrised FIFO with registered read data, occupancy count,
// programmable almost flags and one-cycle overflow/underflow pulses.
module sfifo_p #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic      clk,
  input  logic      rst,
  sfifo_p_if.slave  bus
);
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [AW:0] AF_TH = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_TH = AE_LEVEL[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      occ_p0;
  logic             full_p0;
  logic             empty_p0;
  logic             wr_en_p0;
  logic             rd_en_p0;

  logic [WIDTH-1:0] rdata_p1;
  logic             vld_p1;
  logic             ovf_p1;
  logic             unf_p1;

  // Stage 0: status from pre-edge pointers; the wrap bit separates full from empty
  always_comb begin
    occ_p0   = wptr - rptr;
    empty_p0 = (wptr == rptr);
    full_p0  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    wr_en_p0 = bus.wsig && !full_p0;
    rd_en_p0 = bus.rsig && !empty_p0;
  end

  always_ff @(posedge clk) begin
    if (wr_en_p0) mem[wptr[AW-1:0]] <= bus.wdata;
  end

  // Stage 1: pointers, registered read data and per-request pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
      ovf_p1   <= 1'b0;
      unf_p1   <= 1'b0;
    end else begin
      if (wr_en_p0) wptr <= wptr + 1'b1;
      if (rd_en_p0) begin
        rptr     <= rptr + 1'b1;
        rdata_p1 <= mem[rptr[AW-1:0]];
      end
      vld_p1 <= rd_en_p0;
      ovf_p1 <= bus.wsig && full_p0;
      unf_p1 <= bus.rsig && empty_p0;
    end
  end

  assign bus.rdata        = rdata_p1;
  assign bus.rvalid       = vld_p1;
  assign bus.overflow     = ovf_p1;
  assign bus.underflow    = unf_p1;
  assign bus.count        = occ_p0;
  assign bus.full         = full_p0;
  assign bus.empty        = empty_p0;
  assign bus.almost_full  = (occ_p0 >= AF_TH);
  assign bus.almost_empty = (occ_p0 <= AE_TH);
endmodule

// File: tb/tb_sfifo_p.sv
// Directed bench for sfifo_p: default 8x8 instance plus a 16x4 parameter variant.
module tb_sfifo_p;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sfifo_p_if #(.WIDTH(8),  .DEPTH(8)) bus_a ();
  sfifo_p_if #(.WIDTH(16), .DEPTH(4)) bus_b ();

  sfifo_p #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  sfifo_p #(.WIDTH(16), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  typedef struct {
    bit         w;
    logic [7:0] wd;
    bit         r;
    int         cnt;
    bit         ov;
    bit         un;
    bit         rv;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(bit w, logic [7:0] wd, bit r, int cnt,
                              bit ov, bit un, bit rv, logic [7:0] rd);
    vec_t v;
    v.w = w; v.wd = wd; v.r = r; v.cnt = cnt;
    v.ov = ov; v.un = un; v.rv = rv; v.rd = rd;
    vecs.push_back(v);
  endfunction

  task automatic cyc_a(input bit w, input logic [7:0] wd, input bit r);
    @(negedge clk);
    bus_a.wsig = w; bus_a.wdata = wd; bus_a.rsig = r;
    @(posedge clk);
    #1;
    bus_a.wsig = 1'b0; bus_a.rsig = 1'b0;
  endtask

  task automatic cyc_b(input bit w, input logic [15:0] wd, input bit r);
    @(negedge clk);
    bus_b.wsig = w; bus_b.wdata = wd; bus_b.rsig = r;
    @(posedge clk);
    #1;
    bus_b.wsig = 1'b0; bus_b.rsig = 1'b0;
  endtask

  // Status of the default instance: full/empty/almost flags follow from count.
  task automatic chk_status_a(input string tag, input int cnt);
    chk({tag, " count"}, 32'(bus_a.count), 32'(cnt));
    chk({tag, " flags"},
        {28'd0, bus_a.full, bus_a.empty, bus_a.almost_full, bus_a.almost_empty},
        {28'd0, cnt == 8, cnt == 0, cnt >= 7, cnt <= 1});
  endtask

  task automatic chk_status_b(input string tag, input int cnt);
    chk({tag, " count"}, 32'(bus_b.count), 32'(cnt));
    chk({tag, " flags"},
        {28'd0, bus_b.full, bus_b.empty, bus_b.almost_full, bus_b.almost_empty},
        {28'd0, cnt == 4, cnt == 0, cnt >= 3, cnt == 0});
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_rd;
    string      tag;

    rst = 1'b0;
    bus_a.wsig = 1'b0; bus_a.wdata = '0; bus_a.rsig = 1'b0;
    bus_b.wsig = 1'b0; bus_b.wdata = '0; bus_b.rsig = 1'b0;

    // fill, overflow, drain, underflow, simultaneous at both boundaries
    for (int i = 0; i < 8; i++) add(1'b1, 8'(i), 1'b0, i + 1, 1'b0, 1'b0, 1'b0, 8'h00);
    add(1'b1, 8'hFF, 1'b0, 8, 1'b1, 1'b0, 1'b0, 8'h00);
    add(1'b0, 8'h00, 1'b0, 8, 1'b0, 1'b0, 1'b0, 8'h00);
    add(1'b1, 8'hEE, 1'b1, 7, 1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 1; i < 8; i++) add(1'b0, 8'h00, 1'b1, 7 - i, 1'b0, 1'b0, 1'b1, 8'(i));
    add(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h07);
    add(1'b1, 8'h3C, 1'b1, 1, 1'b0, 1'b1, 1'b0, 8'h07);
    add(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'h3C);
    add(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h3C);

    repeat (2) @(posedge clk);
    #1;
    chk_status_a("reset_a", 0);
    chk("reset_a rdata", 32'(bus_a.rdata), 32'h0);
    chk("reset_a pulses", {29'd0, bus_a.rvalid, bus_a.overflow, bus_a.underflow}, 32'h0);
    chk_status_b("reset_b", 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      cyc_a(vecs[i].w, vecs[i].wd, vecs[i].r);
      tag = $sformatf("vec%0d", i);
      chk_status_a(tag, vecs[i].cnt);
      chk({tag, " pulses"}, {29'd0, bus_a.rvalid, bus_a.overflow, bus_a.underflow},
          {29'd0, vecs[i].rv, vecs[i].ov, vecs[i].un});
      chk({tag, " rdata"}, 32'(bus_a.rdata), 32'(vecs[i].rd));
    end

    // steady state at count 3 across pointer wrap
    for (int k = 0; k < 3; k++) begin
      cyc_a(1'b1, 8'(8'h80 + k), 1'b0);
      q.push_back(8'(8'h80 + k));
    end
    for (int k = 0; k < 20; k++) begin
      cyc_a(1'b1, 8'(8'h40 + k), 1'b1);
      exp_rd = q.pop_front();
      q.push_back(8'(8'h40 + k));
      tag = $sformatf("wrap%0d", k);
      chk({tag, " rdata"}, 32'(bus_a.rdata), 32'(exp_rd));
      chk({tag, " rvalid/err"}, {29'd0, bus_a.rvalid, bus_a.overflow, bus_a.underflow}, 32'h4);
      chk({tag, " count"}, 32'(bus_a.count), 32'd3);
    end
    for (int k = 0; k < 3; k++) begin
      cyc_a(1'b0, 8'h00, 1'b1);
      exp_rd = q.pop_front();
      chk($sformatf("drain%0d rdata", k), 32'(bus_a.rdata), 32'(exp_rd));
    end
    chk_status_a("drained", 0);

    // asynchronous reset between edges with data in flight
    cyc_a(1'b1, 8'h11, 1'b0);
    cyc_a(1'b1, 8'h22, 1'b0);
    cyc_a(1'b1, 8'h33, 1'b1);
    chk("pre_rst rdata", 32'(bus_a.rdata), 32'h11);
    chk_status_a("pre_rst", 2);
    #2;
    rst = 1'b0;
    #1;
    chk_status_a("mid_rst", 0);
    chk("mid_rst rdata", 32'(bus_a.rdata), 32'h0);
    chk("mid_rst pulses", {29'd0, bus_a.rvalid, bus_a.overflow, bus_a.underflow}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cyc_a(1'b1, 8'hA5, 1'b0);
    chk_status_a("post_rst wr", 1);
    cyc_a(1'b0, 8'h00, 1'b1);
    chk("post_rst rdata", 32'(bus_a.rdata), 32'hA5);
    chk("post_rst rvalid", 32'(bus_a.rvalid), 32'h1);
    cyc_a(1'b0, 8'h00, 1'b0);
    chk("post_rst rvalid drop", 32'(bus_a.rvalid), 32'h0);

    // WIDTH=16, DEPTH=4, AF_LEVEL=3, AE_LEVEL=0 variant
    chk_status_b("b_init", 0);
    cyc_b(1'b1, 16'hBEEF, 1'b0); chk_status_b("b_w1", 1);
    cyc_b(1'b1, 16'h1111, 1'b0); chk_status_b("b_w2", 2);
    cyc_b(1'b1, 16'h2222, 1'b0); chk_status_b("b_w3", 3);
    cyc_b(1'b1, 16'h3333, 1'b0); chk_status_b("b_w4", 4);
    cyc_b(1'b1, 16'h4444, 1'b0);
    chk("b_ovf", 32'(bus_b.overflow), 32'h1);
    chk_status_b("b_ovf", 4);
    cyc_b(1'b0, 16'h0000, 1'b1);
    chk("b_rd1 rdata", 32'(bus_b.rdata), 32'hBEEF);
    chk("b_rd1 rvalid", 32'(bus_b.rvalid), 32'h1);
    chk_status_b("b_rd1", 3);
    cyc_b(1'b0, 16'h0000, 1'b1);
    chk("b_rd2 rdata", 32'(bus_b.rdata), 32'h1111);
    chk_status_b("b_rd2", 2);
    cyc_b(1'b0, 16'h0000, 1'b1);
    chk_status_b("b_rd3", 1);
    cyc_b(1'b0, 16'h0000, 1'b1);
    chk("b_rd4 rdata", 32'(bus_b.rdata), 32'h3333);
    chk_status_b("b_rd4", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sfifo_p.md
# sfifo_p

Parametrised synchronous FIFO: the next-generation single-clock buffer for datapath staging between producer and consumer blocks. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags and per-cycle overflow/underflow error pulses. Read data is registered, so data appears one cycle after an accepted read.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AW, $clog2(DEPTH), pointer index width; derived, not overridden
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- wsig  in  1  write request
- wdata  in  WIDTH  write data, sampled with wsig
- rsig  in  1  read request
- rdata  out  WIDTH  registered read data
- rvalid  out  1  rdata updated this cycle (1-cycle pulse)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  write rejected this cycle (1-cycle pulse)
- underflow  out  1  read rejected this cycle (1-cycle pulse)

## Operation
- Storage: DEPTH x WIDTH array; not reset. Pointers wptr/rptr are AW+1 bits; low AW bits index, MSB is wrap bit.
- full = (low bits equal, MSBs differ); empty = (wptr == rptr); count = wptr − rptr modulo 2^(AW+1).
- Write accepted iff wsig && !full: mem[wptr[AW-1:0]] <= wdata, wptr += 1.
- Read accepted iff rsig && !empty: rdata <= mem[rptr[AW-1:0]], rptr += 1, rvalid <= 1.
- Flags evaluated on pre-edge state; write and read decisions are independent.
- Simultaneous wsig and rsig:
  - neither full nor empty: both accepted, count unchanged.
  - empty: write accepted, read rejected (underflow pulse); no bypass of the written word.
  - full: read accepted, write rejected (overflow pulse).
- wsig when full → overflow=1 next cycle, memory and wptr untouched. rsig when empty → underflow=1, rdata holds previous value, rvalid=0.
- Pointer wrap: index rolls DEPTH−1 → 0 and MSB toggles; no special handling.
- rdata holds its last value until the next accepted read.

## Timing
- Reset (rst=0, asynchronous assert, any time): wptr=rptr=0, rdata=0, rvalid=0, overflow=0, underflow=0. Hence empty=1, full=0, count=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), i.e. 0 for legal AF_LEVEL. Contents in flight are discarded; memory is not cleared.
- Deassertion is expected synchronous to clk (synchroniser outside block); first request sampled on the first rising edge with rst=1.
- Write latency: word written at edge N is readable by rsig at edge N+1 (empty deasserts after edge N).
- Read latency: rsig accepted at edge N → rdata/rvalid valid after edge N, i.e. usable in cycle N+1.
- full/empty/count/almost_* are combinational from pointers: updated the cycle after the causing edge.
- overflow/underflow/rvalid registered, asserted exactly one cycle per offending/accepted request.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Reset mid-operation: write 3 words, assert rst=0 between edges → immediately count=0, empty=1, rdata=0; after release, write 0xA5 then read → rdata=0xA5, rvalid pulse.
- Fill to full (defaults): write 0x00..0x07 → full=1 after 8th write, almost_full=1 from count=7; 9th write 0xFF → overflow=1 one cycle, count stays 8; read 8 → rdata 0x00..0x07 in order.
- Underflow: read on empty → underflow=1 one cycle, rvalid=0, rdata unchanged, count=0.
- Simultaneous at boundaries: full + wsig&rsig → rdata=oldest, overflow=1, count 8→7; empty + wsig&rsig → underflow=1, count 0→1, next read returns written word.
- Wrap-around: 20 interleaved write/read pairs at count 3 steady state → data order preserved across pointer wrap, count constant 3, no error pulses.
- Parameter sweep: WIDTH=16, DEPTH=4, AF_LEVEL=3, AE_LEVEL=0 → almost_full at count 3, almost_empty only at 0, full at 4, 0xBEEF round-trips.
